// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types, widths and control-strobe decode for the RTC bus sequencer
package rtc_pkg;
  localparam int RTC_AW = 8;
  localparam int RTC_DW = 8;
  localparam int T_PH_DEF = 4;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_DATA_SETUP,
    ST_DATA_STROBE,
    ST_DATA_HOLD,
    ST_DONE
  } state_t;
  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_n;
    logic ad_oe;
    logic mux_en;
    logic busy;
    logic done;
  } bus_ctl_t;
  // The address is always written to the RTC, so only the data phase depends on rw.
  function automatic bus_ctl_t decode(input state_t s, input logic rw);
    logic addr_ph;
    logic data_ph;
    addr_ph = s inside {ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD};
    data_ph = s inside {ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD};
    decode.cs_n   = !(addr_ph || data_ph);
    decode.rd_n   = !(s == ST_DATA_STROBE && rw);
    decode.wr_n   = !(s == ST_ADDR_STROBE || (s == ST_DATA_STROBE && !rw));
    decode.ad_n   = !addr_ph;
    decode.ad_oe  = addr_ph || (data_ph && !rw);
    decode.mux_en = data_ph;
    decode.busy   = s != ST_IDLE;
    decode.done   = s == ST_DONE;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-state down-counter; expired marks the last cycle of a T_PH-long phase
module phase_timer #(
  parameter int T_PH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(T_PH) + 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (load) r_cnt <= W'(T_PH - 1);
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign expired = r_cnt == '0;
endmodule

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: runs one read or write on the RTC multiplexed address/data bus
// Outputs are decoded from the next state and registered, so they line up with the state.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_PH = T_PH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [RTC_AW-1:0] addr,
  input  logic [RTC_DW-1:0] wdata,
  input  logic [RTC_DW-1:0] ad_in,
  output logic              busy,
  output logic              done,
  output logic [RTC_DW-1:0] rdata,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ad_n,
  output logic              ad_oe,
  output logic              mux_en,
  output logic [RTC_AW-1:0] addr_q,
  output logic [RTC_DW-1:0] wdata_q
);
  state_t   r_state;
  state_t   w_next;
  bus_ctl_t r_ctl;
  logic     r_rw;
  logic     w_exp;
  logic     w_acc;
  assign w_acc = r_state == ST_IDLE && start;
  phase_timer #(.T_PH(T_PH)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_next != r_state),
    .expired(w_exp)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE) w_next = start ? ST_ADDR_SETUP : ST_IDLE;
    else if (r_state == ST_DONE) w_next = ST_IDLE;
    else if (w_exp) w_next = state_t'(r_state + 3'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ctl   <= decode(ST_IDLE, 1'b0);
      r_rw    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= decode(w_next, w_acc ? rw : r_rw);
      if (w_acc) begin
        r_rw    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (r_state == ST_DATA_STROBE && w_exp && r_rw) rdata <= ad_in;
    end
  end
  assign {cs_n, rd_n, wr_n, ad_n, ad_oe, mux_en, busy, done} = r_ctl;
endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb_rtc_bus_cycle: directed checks of the RTC bus sequencer at T_PH=4 and T_PH=1
module tb_rtc_bus_cycle;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic reset1 = 1'b1, start1 = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, ad_in = 8'h00;
  logic busy, done, cs_n, rd_n, wr_n, ad_n, ad_oe, mux_en;
  logic [7:0] rdata, addr_q, wdata_q;
  logic busy1, done1, cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, mux_en1;
  logic [7:0] rdata1, addr_q1, wdata_q1;
  int checks = 0, errors = 0;
  int n_wa, n_wd, n_rd, n_doe, n_done, k_done;
  logic [7:0] rdata_at_done;

  always #5 clk = ~clk;

  rtc_bus_cycle #(.T_PH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata), .ad_in(ad_in),
    .busy(busy), .done(done), .rdata(rdata), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .ad_oe(ad_oe), .mux_en(mux_en), .addr_q(addr_q), .wdata_q(wdata_q)
  );

  rtc_bus_cycle #(.T_PH(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .rw(rw), .addr(addr), .wdata(wdata), .ad_in(ad_in),
    .busy(busy1), .done(done1), .rdata(rdata1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_n(ad_n1),
    .ad_oe(ad_oe1), .mux_en(mux_en1), .addr_q(addr_q1), .wdata_q(wdata_q1)
  );

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert ((rd_n || wr_n) && !(ad_oe && !rd_n)) else begin
        errors++;
        $error("FAIL strobe_excl: rd_n=%b wr_n=%b ad_oe=%b expected no overlap", rd_n, wr_n, ad_oe);
      end
    end
    if (!reset1) begin
      checks++;
      assert ((rd_n1 || wr_n1) && !(ad_oe1 && !rd_n1)) else begin
        errors++;
        $error("FAIL strobe_excl1: rd_n=%b wr_n=%b ad_oe=%b expected no overlap", rd_n1, wr_n1, ad_oe1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_addr_q"}, int'(addr_q), 0);
    chk({tag, "_wdata_q"}, int'(wdata_q), 0);
    chk({tag, "_strobes"}, int'({cs_n, rd_n, wr_n, ad_n}), 4'hF);
    chk({tag, "_oe_mux"}, int'({ad_oe, mux_en}), 0);
  endtask

  // Accept at edge E, then observe cycles k=1..25 (cycle k begins at edge E+k).
  task automatic run_txn(input logic i_rw, input logic [7:0] a, input logic [7:0] d, input bit pulse);
    rw = i_rw; addr = a; wdata = d; start = 1'b1;
    step();
    start = 1'b0; rw = ~i_rw; addr = 8'hFF; wdata = 8'h00;
    chk("accept_busy", int'(busy), 1);
    n_wa = 0; n_wd = 0; n_rd = 0; n_doe = 0; n_done = 0; k_done = 0; rdata_at_done = 8'h00;
    for (int k = 1; k <= 25; k++) begin
      if (!wr_n && !ad_n && !mux_en) n_wa++;
      if (!wr_n && ad_n && mux_en) n_wd++;
      if (!rd_n) n_rd++;
      if (!cs_n && ad_n && ad_oe) n_doe++;
      if (done) begin
        n_done++;
        if (k_done == 0) begin k_done = k; rdata_at_done = rdata; end
      end
      if (k == 25) chk("busy_with_done", int'(busy), 1);
      start = pulse && (k == 3 || k == 10 || k == 25);
      ad_in = (k >= 17 && k <= 20) ? 8'hA7 : 8'h5A;
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check_reset_outputs("reset");
    start = 1'b1; rw = 1'b0; addr = 8'h33; wdata = 8'h44;
    step();
    chk("start_in_reset_busy", int'(busy), 0);
    chk("start_in_reset_addr_q", int'(addr_q), 0);
    reset = 1'b0; start = 1'b0;
    step();
    chk("after_reset_busy", int'(busy), 0);

    run_txn(1'b0, 8'h21, 8'h59, 1'b0);
    chk("wr_addr_q", int'(addr_q), 8'h21);
    chk("wr_wdata_q", int'(wdata_q), 8'h59);
    chk("wr_n_addr_cycles", n_wa, 4);
    chk("wr_n_data_cycles", n_wd, 4);
    chk("wr_rd_n_cycles", n_rd, 0);
    chk("wr_data_oe_cycles", n_doe, 12);
    chk("wr_done_cycle", k_done, 25);
    chk("wr_done_count", n_done, 1);
    chk("wr_idle_busy", int'(busy), 0);
    chk("wr_idle_done", int'(done), 0);

    run_txn(1'b1, 8'h22, 8'h00, 1'b0);
    chk("rd_addr_q", int'(addr_q), 8'h22);
    chk("rd_n_cycles", n_rd, 4);
    chk("rd_addr_write_cycles", n_wa, 4);
    chk("rd_data_wr_cycles", n_wd, 0);
    chk("rd_data_oe_cycles", n_doe, 0);
    chk("rd_done_cycle", k_done, 25);
    chk("rd_rdata_at_done", int'(rdata_at_done), 8'hA7);
    ad_in = 8'h3C;
    repeat (3) step();
    chk("rd_rdata_held", int'(rdata), 8'hA7);

    run_txn(1'b0, 8'h10, 8'h77, 1'b1);
    chk("ign_done_count", n_done, 1);
    chk("ign_done_cycle", k_done, 25);
    chk("ign_not_queued", int'(busy), 0);
    chk("wr_keeps_rdata", int'(rdata), 8'hA7);
    run_txn(1'b0, 8'h11, 8'h88, 1'b0);
    chk("b2b_done_cycle", k_done, 25);
    chk("b2b_wdata_q", int'(wdata_q), 8'h88);

    rw = 1'b0; addr = 8'h05; wdata = 8'h06; start = 1'b1;
    step();
    start = 1'b0;
    repeat (17) step();
    chk("mid_wr_n_strobe", int'(wr_n), 0);
    chk("mid_mux_en", int'(mux_en), 1);
    reset = 1'b1;
    step();
    chk("mid_reset_wr_n", int'(wr_n), 1);
    chk("mid_reset_cs_n", int'(cs_n), 1);
    chk("mid_reset_ad_oe", int'(ad_oe), 0);
    chk("mid_reset_busy", int'(busy), 0);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) n_done++;
      step();
    end
    chk("mid_reset_no_done", n_done, 0);

    reset1 = 1'b0;
    step();
    rw = 1'b0; addr = 8'h2A; wdata = 8'hC3; start1 = 1'b1;
    step();
    start1 = 1'b0;
    n_wa = 0; n_wd = 0; n_done = 0; k_done = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!wr_n1 && !ad_n1 && !mux_en1) n_wa++;
      if (!wr_n1 && ad_n1 && mux_en1) n_wd++;
      if (done1) begin n_done++; if (k_done == 0) k_done = k; end
      step();
    end
    chk("t1_done_cycle", k_done, 7);
    chk("t1_done_count", n_done, 1);
    chk("t1_wr_addr_cycles", n_wa, 1);
    chk("t1_wr_data_cycles", n_wd, 1);
    chk("t1_wdata_q", int'(wdata_q1), 8'hC3);
    chk("t1_idle_busy", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
